// File: rtl/gpc_4t_thread_sched.sv
// Four-thread round-robin fetch scheduler with per-thread PCs, redirect and per-thread PC reset.
// Optional PC range checking is built in when GPC_4T_PC_RANGE_CHECK_EN is defined.
module gpc_4t_thread_sched #(
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic             QClk,
  input  logic             RstQnnnH,
  input  logic [3:0]       EnPc,
  input  logic [3:0]       RstPc,
  input  logic             StallQ100H,
  input  logic             RedirectValid,
  input  logic [1:0]       RedirectThread,
  input  logic [31:0]      RedirectPc,
  output logic [31:0]      PcQ100H,
  output logic [1:0]       ThreadQ100H,
  output logic             ValidQ100H,
  output logic [3:0][31:0] ThreadPc,
  output logic [3:0]       PcExpt
);

  logic [3:0][31:0] pc_q, pc_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       cand;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic             found;
  logic             issue_ok;
  logic             bad_pc;
  logic             fire;

`ifdef GPC_4T_PC_RANGE_CHECK_EN
  logic [3:0] expt_q, expt_d;

  // A flagged thread drops out of arbitration so the others keep issuing.
  assign cand   = EnPc & ~RstPc & ~expt_q;
  assign bad_pc = (|pc_q[sel][21:12]) || (pc_q[sel][23:22] != 2'b00);
  assign PcExpt = expt_q;
`else
  assign cand   = EnPc & ~RstPc;
  assign bad_pc = 1'b0;
  assign PcExpt = '0;
`endif

  // Search order LastQ+1, +2, +3, then LastQ itself.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    idx   = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign issue_ok    = found && !StallQ100H;
  assign fire        = issue_ok && !bad_pc;
  assign ValidQ100H  = fire;
  assign ThreadQ100H = fire ? sel : last_q;
  assign PcQ100H     = pc_q[ThreadQ100H];
  assign ThreadPc    = pc_q;

  always_comb begin
    pc_d   = pc_q;
    last_d = last_q;
    if (fire) begin
      pc_d[sel] = pc_q[sel] + 32'd4;
      last_d    = sel;
    end
    if (RedirectValid) pc_d[RedirectThread] = RedirectPc;
    for (int unsigned n = 0; n < 4; n++) begin
      if (RstPc[n]) pc_d[n] = RST_PC;
    end
  end

`ifdef GPC_4T_PC_RANGE_CHECK_EN
  always_comb begin
    expt_d = expt_q;
    if (issue_ok && bad_pc) expt_d[sel] = 1'b1;
    expt_d = expt_d & ~RstPc;
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) expt_q <= '0;
    else          expt_q <= expt_d;
  end
`endif

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      pc_q   <= {4{RST_PC}};
      last_q <= 2'd3;
    end else begin
      pc_q   <= pc_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_gpc_4t_thread_sched.sv
// Directed bench for gpc_4t_thread_sched: rotation, masking, redirect, stall, per-thread reset.
module tb_gpc_4t_thread_sched;
  logic             QClk = 1'b0;
  logic             RstQnnnH;
  logic [3:0]       EnPc;
  logic [3:0]       RstPc;
  logic             StallQ100H;
  logic             RedirectValid;
  logic [1:0]       RedirectThread;
  logic [31:0]      RedirectPc;
  logic [31:0]      PcQ100H;
  logic [1:0]       ThreadQ100H;
  logic             ValidQ100H;
  logic [3:0][31:0] ThreadPc;
  logic [3:0]       PcExpt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  gpc_4t_thread_sched #(.RST_PC(32'h0000_0000)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH), .EnPc(EnPc), .RstPc(RstPc),
    .StallQ100H(StallQ100H), .RedirectValid(RedirectValid),
    .RedirectThread(RedirectThread), .RedirectPc(RedirectPc),
    .PcQ100H(PcQ100H), .ThreadQ100H(ThreadQ100H), .ValidQ100H(ValidQ100H),
    .ThreadPc(ThreadPc), .PcExpt(PcExpt)
  );

  always #5 QClk = ~QClk;

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic v, input logic [1:0] t, input logic [31:0] pc);
    #1;
    chk({tag, "_valid"}, 32'(ValidQ100H), 32'(v));
    chk({tag, "_thread"}, 32'(ThreadQ100H), 32'(t));
    chk({tag, "_pc"}, PcQ100H, pc);
  endtask

  initial begin
    RstQnnnH = 1'b1; EnPc = '0; RstPc = '0; StallQ100H = 1'b0;
    RedirectValid = 1'b0; RedirectThread = '0; RedirectPc = '0;
    tick();
    chk_issue("in_reset", 1'b0, 2'd3, 32'h0);
    tick();
    RstQnnnH = 1'b0;
    tick();
    chk_issue("post_reset_idle", 1'b0, 2'd3, 32'h0);
    chk("post_reset_expt", 32'(PcExpt), 32'h0);

    // All four enabled: 0,1,2,3,0 with PCs 0,0,0,0,4
    EnPc = 4'b1111;
    chk_issue("rr0", 1'b1, 2'd0, 32'h0); tick();
    chk_issue("rr1", 1'b1, 2'd1, 32'h0); tick();
    chk_issue("rr2", 1'b1, 2'd2, 32'h0); tick();
    chk_issue("rr3", 1'b1, 2'd3, 32'h0); tick();
    chk_issue("rr4", 1'b1, 2'd0, 32'h4); tick();
    chk("rr_pc0", ThreadPc[0], 32'h8);
    chk("rr_pc3", ThreadPc[3], 32'h4);

    // Alternate threads 0 and 2
    RstQnnnH = 1'b1; EnPc = 4'b0101; tick(); RstQnnnH = 1'b0;
    chk_issue("alt0", 1'b1, 2'd0, 32'h0); tick();
    chk_issue("alt1", 1'b1, 2'd2, 32'h0); tick();
    chk_issue("alt2", 1'b1, 2'd0, 32'h4); tick();
    chk_issue("alt3", 1'b1, 2'd2, 32'h4); tick();
    chk("alt_pc1", ThreadPc[1], 32'h0);
    chk("alt_pc3", ThreadPc[3], 32'h0);
    chk("alt_pc2", ThreadPc[2], 32'h8);

    // Single thread 1; redirect beats +4 on its third issue
    RstQnnnH = 1'b1; EnPc = 4'b0010; tick(); RstQnnnH = 1'b0;
    chk_issue("one0", 1'b1, 2'd1, 32'h0); tick();
    chk_issue("one1", 1'b1, 2'd1, 32'h4); tick();
    RedirectValid = 1'b1; RedirectThread = 2'd1; RedirectPc = 32'h100;
    chk_issue("redir_issue", 1'b1, 2'd1, 32'h8); tick();
    RedirectValid = 1'b0;
    chk("redir_pc1", ThreadPc[1], 32'h100);

    // Stall freezes rotation and PCs
    EnPc = 4'b1111;
    chk_issue("pre_stall", 1'b1, 2'd2, 32'h0); tick();
    StallQ100H = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_issue("stall", 1'b0, 2'd2, 32'h4);
      tick();
    end
    chk("stall_pc2", ThreadPc[2], 32'h4);
    chk("stall_pc3", ThreadPc[3], 32'h0);
    StallQ100H = 1'b0;
    chk_issue("resume0", 1'b1, 2'd3, 32'h0); tick();
    chk_issue("resume1", 1'b1, 2'd0, 32'h0); tick();

    // RstPc[2] beats a redirect of thread 2 and masks it from arbitration
    RstPc = 4'b0100; RedirectValid = 1'b1; RedirectThread = 2'd2; RedirectPc = 32'h200;
    chk_issue("rstpc_issue", 1'b1, 2'd1, 32'h100); tick();
    RedirectValid = 1'b0;
    chk("rstpc_pc2", ThreadPc[2], 32'h0);
    chk("rstpc_pc1", ThreadPc[1], 32'h104);
    chk_issue("rstpc_skip", 1'b1, 2'd3, 32'h4); tick();
    RstPc = '0;
    chk_issue("rstpc_after", 1'b1, 2'd0, 32'h4);

    // Disabled threads keep PCs and nothing issues
    EnPc = '0;
    chk_issue("none_en", 1'b0, 2'd3, 32'h8);
    tick();
    chk("none_pc3", ThreadPc[3], 32'h8);
    chk("none_pc0", ThreadPc[0], 32'h4);

`ifdef GPC_4T_PC_RANGE_CHECK_EN
    RstQnnnH = 1'b1; EnPc = 4'b0011; tick(); RstQnnnH = 1'b0;
    RedirectValid = 1'b1; RedirectThread = 2'd0; RedirectPc = 32'h1000;
    chk_issue("rc_issue0", 1'b1, 2'd0, 32'h0); tick();
    RedirectValid = 1'b0;
    chk_issue("rc_issue1", 1'b1, 2'd1, 32'h0); tick();
    chk_issue("rc_suppress", 1'b0, 2'd1, 32'h4); tick();
    chk("rc_expt", 32'(PcExpt), 32'h1);
    chk("rc_pc0", ThreadPc[0], 32'h1000);
    chk_issue("rc_other", 1'b1, 2'd1, 32'h4);
    RstPc = 4'b0001; tick(); RstPc = '0;
    chk("rc_clear", 32'(PcExpt), 32'h0);
`else
    chk("expt_tied", 32'(PcExpt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpc_4t_thread_sched.md
GPC_4T_THREAD_SCHED -- requirements
Module: gpc_4t_thread_sched

Interface
REQ-001 SHALL have parameter RST_PC, default 32'h0000_0000: value loaded into a thread PC on reset or rst_pc.
REQ-002 SHALL have port QClk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port RstQnnnH, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port EnPc, input, 4 bits: per-thread fetch enable (CR en_pc_0..3; bit n = thread n).
REQ-005 SHALL have port RstPc, input, 4 bits: per-thread PC reset request (CR rst_pc_0..3).
REQ-006 SHALL have port StallQ100H, input, 1 bit: pipeline stall; freezes the scheduler.
REQ-007 SHALL have port RedirectValid, input, 1 bit: branch/jump redirect strobe.
REQ-008 SHALL have port RedirectThread, input, 2 bits: thread that is redirected.
REQ-009 SHALL have port RedirectPc, input, 32 bits: new PC for RedirectThread.
REQ-010 SHALL have port PcQ100H, output, 32 bits: fetch address issued this cycle.
REQ-011 SHALL have port ThreadQ100H, output, 2 bits: thread owning PcQ100H.
REQ-012 SHALL have port ValidQ100H, output, 1 bit: PcQ100H/ThreadQ100H are a real fetch.
REQ-013 SHALL have port ThreadPc, output, 4x32 bits: current PC per thread (feeds CR pc_0..3).
REQ-014 SHALL have port PcExpt, output, 4 bits: per-thread PC out-of-range flag (CR sts_n bit 0).

Function
REQ-015 SHALL hold one 32-bit PC register and one PcExpt bit per thread, plus a 2-bit last-issued pointer LastQ.
REQ-016 SHALL select the issuing thread combinationally: first thread with EnPc=1 and RstPc=0, searching LastQ+1, LastQ+2, LastQ+3, LastQ (mod 4, wrap 3->0).
REQ-017 SHALL drive ValidQ100H=1, ThreadQ100H=selected, PcQ100H=ThreadPc[selected] when a candidate exists and StallQ100H=0; otherwise ValidQ100H=0, ThreadQ100H=LastQ, PcQ100H=ThreadPc[LastQ].
REQ-018 SHALL, on the edge after a valid issue, set LastQ to the issued thread and add 4 to that thread's PC (32-bit wrap, no carry out).
REQ-019 SHALL, while StallQ100H=1, leave LastQ and all PCs unchanged except via redirect or RstPc.
REQ-020 SHALL, when RedirectValid=1, load RedirectPc into ThreadPc[RedirectThread] on the next edge; redirect wins over the +4 of a simultaneous issue of the same thread.
REQ-021 SHALL, when RstPc[n]=1, load RST_PC into ThreadPc[n] and clear PcExpt[n] on the next edge; RstPc wins over redirect and issue.
REQ-022 SHALL ignore EnPc changes mid-cycle; a thread disabled with EnPc=0 keeps its PC.
REQ-023 SHALL produce a single issue with one thread enabled (same thread every non-stalled cycle) and ValidQ100H=0 with none enabled.
REQ-024 SHALL have zero-cycle latency from state to PcQ100H (combinational output of registered state).

Reset
REQ-025 SHALL, on RstQnnnH=1 at a clock edge, set every ThreadPc to RST_PC, PcExpt to 4'b0, LastQ to 2'd3 (so thread 0 issues first).
REQ-026 SHALL give reset priority over RstPc, redirect, stall and issue; reset mid-operation discards all in-flight updates.
REQ-027 SHALL drive, during and after reset until the first enabled cycle, ValidQ100H=0, ThreadQ100H=2'd3, PcQ100H=RST_PC.

Configuration
REQ-028 SHALL implement PC range checking only when macro GPC_4T_PC_RANGE_CHECK_EN is defined.
REQ-029 SHALL, with GPC_4T_PC_RANGE_CHECK_EN defined, set PcExpt[n] (sticky) when thread n issues a PC with any of bits [21:12] nonzero or region bits [23:22] not I_MEM_REGION (2'b00), and suppress that issue (ValidQ100H=0, no +4, LastQ unchanged).
REQ-030 SHALL, without GPC_4T_PC_RANGE_CHECK_EN, tie PcExpt to 4'b0 and never suppress issue.

Verification
REQ-031 SHALL cover: reset, EnPc=4'b1111 -> ThreadQ100H 0,1,2,3,0 with PcQ100H 0,0,0,0,4.
REQ-032 SHALL cover: EnPc=4'b0101 -> thread sequence 0,2,0,2; threads 1,3 PCs stay 0.
REQ-033 SHALL cover: thread 1 issue at PC 8 with RedirectValid=1, RedirectThread=1, RedirectPc=32'h100 -> ThreadPc[1]=32'h100 next cycle, not 32'hC.
REQ-034 SHALL cover: StallQ100H=1 for 3 cycles -> ValidQ100H=0, all PCs and LastQ frozen; resume continues rotation where it stopped.
REQ-035 SHALL cover: RstPc[2]=1 with RedirectValid for thread 2 -> ThreadPc[2]=RST_PC; thread 2 skipped while RstPc[2]=1.
REQ-036 SHALL cover (GPC_4T_PC_RANGE_CHECK_EN): redirect thread 0 to 32'h0000_1000 -> PcExpt[0]=1, thread 0 issues suppressed, others unaffected; RstPc[0] clears it.
